// File: rtl/hnf_txreq.sv
// hnf_txreq: HN-F TXREQ link-layer stage.
// Buffers miss/forward requests bound for the SN in a small FIFO and drives the
// CHI TXREQ channel. A flit is sent only while an L-credit is held.
// Optional feature macro: HNF_TXREQ_STALL_CNT_EN adds the txreq_stall_cnt port.
module hnf_txreq #(
  parameter type         reqflit_t  = logic [96:0],
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_CRD    = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  reqflit_t    miss_req,
  input  logic        miss_req_v,
  output logic        miss_req_rdy,
  output reqflit_t    txreqflit,
  output logic        txreqflitv,
  output logic        txreqflitpend,
  input  logic        txreqlcrdv,
  output logic [3:0]  txreq_crd_cnt,
  output logic        txreq_crd_ovf
`ifdef HNF_TXREQ_STALL_CNT_EN
  ,
  output logic [31:0] txreq_stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  reqflit_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       crd_cnt;
  logic             push;
  logic             pop;

  // Flop-only status: ready and pending never look at this cycle's inputs.
  assign miss_req_rdy  = (count != CNT_W'(FIFO_DEPTH));
  assign txreqflitpend = (count != '0);
  assign txreq_crd_cnt = crd_cnt;

  // Enqueue/send decision; only credits already registered are spendable.
  always_comb begin
    push = miss_req_v && miss_req_rdy;
    pop  = (count != '0) && (crd_cnt != '0);
  end

  // Request storage; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= miss_req;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // TXREQ flit register; the flit holds its last value when nothing is sent.
  always_ff @(posedge clock) begin
    if (reset) begin
      txreqflit  <= '0;
      txreqflitv <= 1'b0;
    end else begin
      txreqflitv <= pop;
      if (pop) begin
        txreqflit <= mem[rd_ptr];
      end
    end
  end

  // L-credit counter with saturation at MAX_CRD and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      crd_cnt       <= '0;
      txreq_crd_ovf <= 1'b0;
    end else begin
      case ({txreqlcrdv, pop})
        2'b10: begin
          if (crd_cnt == 4'(MAX_CRD)) begin
            txreq_crd_ovf <= 1'b1;
          end else begin
            crd_cnt <= crd_cnt + 4'd1;
          end
        end
        2'b01:   crd_cnt <= crd_cnt - 4'd1;
        default: crd_cnt <= crd_cnt;
      endcase
    end
  end

`ifdef HNF_TXREQ_STALL_CNT_EN
  // Counts cycles with work queued but no credit to send it; saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      txreq_stall_cnt <= '0;
    end else if ((count != '0) && (crd_cnt == '0) && (txreq_stall_cnt != '1)) begin
      txreq_stall_cnt <= txreq_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
